// File: rtl/histogram_peak_finder.sv
// ---------------------------------------------------------------------------
// HistogramPeakFinder (module histogram_peak_finder)
//
// Purpose:
//   Scans a pixel histogram RAM (NBIN = 2**NB bins) after accumulation.
//   Reports the index and score of the fullest bin.
//   One scan runs per accepted start pulse.
//   Ties keep the lowest index because a candidate wins only on a strictly
//   greater score.
//
// Optional feature (macro PEAK_NEIGHBOR_SUM_EN):
//   When defined, each bin is scored by the 3-bin window sum
//   c[k-1] + c[k] + c[k+1]. Neighbours that fall outside the histogram
//   count as 0.
//   This adds one pipeline stage, so peakDone arrives one cycle later.
//   When undefined, the score is the raw bin count and no window logic
//   exists.
//
// Ports:
//   clk        in   rising-edge clock
//   res        in   asynchronous active-high reset
//   start      in   single-cycle scan request, honoured only while idle
//   rd_en      out  histogram RAM read enable
//   rd_addr    out  histogram RAM read address (NB bits)
//   rd_data    in   bin count, valid one cycle after rd_en (CW bits)
//   peakCH     out  winning bin index, held until the next peakDone
//   peakCount  out  winning score (CW+2 bits), held until the next peakDone
//   peakDone   out  one-cycle pulse; peakCH/peakCount are valid with it
//   busy       out  high from the cycle after an accepted start through
//                   the peakDone cycle
// ---------------------------------------------------------------------------
module histogram_peak_finder #(
   parameter int NB = 4,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          res,
   input  logic          start,
   output logic          rd_en,
   output logic [NB-1:0] rd_addr,
   input  logic [CW-1:0] rd_data,
   output logic [NB-1:0] peakCH,
   output logic [CW+1:0] peakCount,
   output logic          peakDone,
   output logic          busy
);

   localparam logic [NB-1:0] LAST_ADDR = {NB{1'b1}};

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN,
      DONE
   } state_t;

   state_t stateQ, stateD;

   logic [NB-1:0] addrQ, addrD;
   logic          validQ;
   logic [NB-1:0] idxQ;
   logic [NB-1:0] bestIdxQ, bestIdxD;
   logic [CW+1:0] bestScoreQ, bestScoreD;
   logic [NB-1:0] peakChQ, peakChD;
   logic [CW+1:0] peakCountQ, peakCountD;

   logic          candValid;
   logic [NB-1:0] candIdx;
   logic [CW+1:0] candScore;
   logic          drainLast;
   logic          startAccepted;

   assign startAccepted = (stateQ == IDLE) && start;

   // State register.
   // Reset can land at any moment, mid-scan included, and always returns
   // the block to IDLE.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         stateQ <= IDLE;
      end else begin
         stateQ <= stateD;
      end
   end

   // Next-state logic.
   // SCAN ends on the read of the last address rather than on the address
   // counter wrapping to zero.
   // DRAIN covers the cycles still needed for in-flight read data to reach
   // the comparator.
   always_comb begin
      stateD = stateQ;
      case (stateQ)
         IDLE:    if (start) stateD = SCAN;
         SCAN:    if (addrQ == LAST_ADDR) stateD = DRAIN;
         DRAIN:   if (drainLast) stateD = DONE;
         DONE:    stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   // Output decode.
   // All control outputs depend on the state register alone.
   // An asynchronous reset therefore clears them without waiting for a
   // clock edge.
   always_comb begin
      rd_en    = (stateQ == SCAN);
      busy     = (stateQ != IDLE);
      peakDone = (stateQ == DONE);
   end

   assign rd_addr   = addrQ;
   assign peakCH    = peakChQ;
   assign peakCount = peakCountQ;

   // Read-return tracking.
   // The RAM answers one cycle after the request.
   // Delaying rd_en and rd_addr by one register tells us when rd_data is
   // meaningful and which bin it belongs to.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         validQ <= 1'b0;
         idxQ   <= '0;
      end else begin
         validQ <= rd_en;
         idxQ   <= rd_addr;
      end
   end

`ifdef PEAK_NEIGHBOR_SUM_EN
   logic [CW-1:0] c1Q;
   logic [CW-1:0] c2Q;
   logic          cenValidQ;
   logic [NB-1:0] cenIdxQ;
   logic          drainQ;
   logic [CW-1:0] upperNb;

   // Window pipeline.
   // c1Q holds the centre bin and c2Q holds its lower neighbour.
   // The upper neighbour is whatever rd_data carries in the same cycle.
   // For the last bin, no read is returning, so the upper neighbour is
   // forced to zero.
   // The history registers are cleared on each accepted start, which makes
   // the lower neighbour of bin 0 read as zero.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         c1Q       <= '0;
         c2Q       <= '0;
         cenValidQ <= 1'b0;
         cenIdxQ   <= '0;
      end else begin
         if (startAccepted) begin
            c1Q <= '0;
            c2Q <= '0;
         end else if (validQ) begin
            c1Q <= rd_data;
            c2Q <= c1Q;
         end
         cenValidQ <= validQ;
         cenIdxQ   <= idxQ;
      end
   end

   // Drain length tracking.
   // The extra window stage stretches DRAIN to two cycles.
   // drainQ marks the second of those cycles.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         drainQ <= 1'b0;
      end else begin
         drainQ <= (stateQ == DRAIN) && !drainQ;
      end
   end

   // Candidate for the comparator: the window centred on the delayed bin.
   always_comb begin
      upperNb   = validQ ? rd_data : '0;
      candValid = cenValidQ;
      candIdx   = cenIdxQ;
      candScore = {2'b00, c2Q} + {2'b00, c1Q} + {2'b00, upperNb};
      drainLast = drainQ;
   end
`else
   // Candidate for the comparator: the raw bin count, zero-extended.
   // DRAIN needs only one cycle in this build.
   always_comb begin
      candValid = validQ;
      candIdx   = idxQ;
      candScore = {2'b00, rd_data};
      drainLast = 1'b1;
   end
`endif

   // Datapath next-state.
   // The address walks 0..NBIN-1 while scanning and parks at zero
   // otherwise.
   // The running best restarts at index 0 with score 0 on every accepted
   // start, and is replaced only by a strictly greater score.
   // The published peak is loaded on the final DRAIN cycle, using the
   // best value that already includes the last compare.
   // That way it is visible in the very cycle peakDone is high.
   always_comb begin
      addrD = addrQ;
      if (stateQ == SCAN) begin
         addrD = (addrQ == LAST_ADDR) ? '0 : addrQ + 1'b1;
      end

      bestIdxD   = bestIdxQ;
      bestScoreD = bestScoreQ;
      if (startAccepted) begin
         bestIdxD   = '0;
         bestScoreD = '0;
      end else if (candValid && (candScore > bestScoreQ)) begin
         bestIdxD   = candIdx;
         bestScoreD = candScore;
      end

      peakChD    = peakChQ;
      peakCountD = peakCountQ;
      if ((stateQ == DRAIN) && drainLast) begin
         peakChD    = bestIdxD;
         peakCountD = bestScoreD;
      end
   end

   // Datapath registers.
   // Everything here clears on reset, including the held peak outputs.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         addrQ      <= '0;
         bestIdxQ   <= '0;
         bestScoreQ <= '0;
         peakChQ    <= '0;
         peakCountQ <= '0;
      end else begin
         addrQ      <= addrD;
         bestIdxQ   <= bestIdxD;
         bestScoreQ <= bestScoreD;
         peakChQ    <= peakChD;
         peakCountQ <= peakCountD;
      end
   end

endmodule

// File: tb/tb_histogram_peak_finder.sv
// ---------------------------------------------------------------------------
// TbHistogramPeakFinder (module tb_histogram_peak_finder)
//
// Directed and randomized scans of histogram_peak_finder against a
// behavioural peak model.
// A small synchronous RAM model feeds rd_data.
// The bench follows PEAK_NEIGHBOR_SUM_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_histogram_peak_finder;

   localparam int NB   = 4;
   localparam int CW   = 16;
   localparam int NBIN = 2**NB;
`ifdef PEAK_NEIGHBOR_SUM_EN
   localparam int DONE_CYC = NBIN + 3;
`else
   localparam int DONE_CYC = NBIN + 2;
`endif

   logic          clk = 1'b0;
   logic          res;
   logic          start;
   logic          rd_en;
   logic [NB-1:0] rd_addr;
   logic [CW-1:0] rd_data = '0;
   logic [NB-1:0] peakCH;
   logic [CW+1:0] peakCount;
   logic          peakDone;
   logic          busy;

   logic [CW-1:0] mem [NBIN];

   int vectors     = 0;
   int miscompares = 0;
   int prevCh      = 0;
   int prevCnt     = 0;

   histogram_peak_finder #(.NB(NB), .CW(CW)) dut (
      .clk       (clk),
      .res       (res),
      .start     (start),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .peakCH    (peakCH),
      .peakCount (peakCount),
      .peakDone  (peakDone),
      .busy      (busy)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   // Histogram RAM model.
   // Data comes back one cycle after a read request.
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   // Reference peak.
   // Score every bin straight from the histogram contents, then keep the
   // first bin that reaches the highest score.
   function automatic void refPeak(output int ch, output int cnt);
      int s;
      ch  = 0;
      cnt = 0;
      for (int k = 0; k < NBIN; k++) begin
         s = int'(mem[k]);
`ifdef PEAK_NEIGHBOR_SUM_EN
         if (k > 0)        s += int'(mem[k-1]);
         if (k < NBIN - 1) s += int'(mem[k+1]);
`endif
         if (s > cnt) begin
            ch  = k;
            cnt = s;
         end
      end
   endfunction

   // One compared vector.
   // A mismatch is counted and reported, and the run carries on.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic fillMem(input int value);
      for (int k = 0; k < NBIN; k++) mem[k] = CW'(value);
   endtask

   // One complete scan.
   // The task is entered and left on a falling edge.
   // It leaves the bench in the cycle right after peakDone, so the next
   // call starts back-to-back.
   // With spam set, start stays high during the whole busy window, and
   // none of those extra requests may be honoured.
   task automatic applyStimulus(input string name, input bit spam);
      int eCh, eCnt;
      refPeak(eCh, eCnt);
      start = 1'b1;
      @(posedge clk);
      for (int cyc = 1; cyc <= DONE_CYC + 1; cyc++) begin
         @(negedge clk);
         start = (spam && cyc < DONE_CYC) ? 1'b1 : 1'b0;
         checkOutput({name, ".rd_en"}, 32'(rd_en), 32'(cyc <= NBIN));
         if (cyc <= NBIN) checkOutput({name, ".rd_addr"}, 32'(rd_addr), 32'(cyc - 1));
         checkOutput({name, ".busy"}, 32'(busy), 32'(cyc <= DONE_CYC));
         checkOutput({name, ".peakDone"}, 32'(peakDone), 32'(cyc == DONE_CYC));
         if (cyc < DONE_CYC) begin
            checkOutput({name, ".heldCH"}, 32'(peakCH), 32'(prevCh));
            checkOutput({name, ".heldCount"}, 32'(peakCount), 32'(prevCnt));
         end else begin
            checkOutput({name, ".peakCH"}, 32'(peakCH), 32'(eCh));
            checkOutput({name, ".peakCount"}, 32'(peakCount), 32'(eCnt));
         end
      end
      start   = 1'b0;
      prevCh  = eCh;
      prevCnt = eCnt;
   endtask

   // Reset checks: every output must be zero.
   task automatic checkResetState(input string name);
      checkOutput({name, ".rd_en"}, 32'(rd_en), 32'd0);
      checkOutput({name, ".rd_addr"}, 32'(rd_addr), 32'd0);
      checkOutput({name, ".busy"}, 32'(busy), 32'd0);
      checkOutput({name, ".peakDone"}, 32'(peakDone), 32'd0);
      checkOutput({name, ".peakCH"}, 32'(peakCH), 32'd0);
      checkOutput({name, ".peakCount"}, 32'(peakCount), 32'd0);
   endtask

   initial begin
      res   = 1'b1;
      start = 1'b0;
      fillMem(0);
      repeat (3) @(negedge clk);
      checkResetState("reset");
      res = 1'b0;

      // Single strong peak over a flat floor.
      fillMem(5);
      mem[9] = 16'd200;
      applyStimulus("singlePeak", 1'b0);

      // Equal scores at both ends: the lowest index must win.
      fillMem(0);
      mem[0]  = 16'd50;
      mem[15] = 16'd50;
      applyStimulus("tieEdges", 1'b0);

      // One count more at the upper end takes over.
      mem[15] = 16'd51;
      applyStimulus("upperEdge", 1'b0);

      // Empty histogram, with start held high throughout the scan.
      fillMem(0);
      applyStimulus("allZeroSpam", 1'b1);

      // Isolated spike against a broad cluster.
      fillMem(0);
      mem[3] = 16'd100;
      mem[7] = 16'd60;
      mem[8] = 16'd60;
      mem[9] = 16'd60;
      applyStimulus("spikeVsCluster", 1'b0);

      // Reset in cycle 8 of a fresh scan.
      // Outputs must clear at once, and the first cycle after release must
      // accept start.
      fillMem(7);
      mem[12] = 16'd900;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      #1 res = 1'b1;
      #1 checkResetState("midScanReset");
      @(negedge clk);
      res     = 1'b0;
      prevCh  = 0;
      prevCnt = 0;
      applyStimulus("afterReset", 1'b0);

      // Random histograms.
      // Wide ranges give distinct peaks; narrow ranges force many ties.
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < NBIN; k++) mem[k] = CW'($urandom_range(0, 65535));
         applyStimulus($sformatf("randWide%0d", r), 1'b0);
      end
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < NBIN; k++) mem[k] = CW'($urandom_range(0, 3));
         applyStimulus($sformatf("randNarrow%0d", r), r[0]);
      end

      // Saturated histogram exercises the widest sums.
      fillMem(65535);
      applyStimulus("allMax", 1'b0);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
